rc_lcu_bitcnt: RTL and testbench

//  Counts the bits CABAC emits for each LCU and for the whole frame. At every LCU end it

---
 rtl/rc_lcu_bitcnt.sv | 121 ++++++++++++
 tb/tb_rc_lcu_bitcnt.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rc_lcu_bitcnt.sv
// rtl/rc_lcu_bitcnt.sv - per-LCU and per-frame CABAC bit counter feeding LCU rate control
//
// Purpose: accumulates the bits CABAC emits each cycle into a per-LCU and a per-frame
// total, and at every LCU end latches the saturated LCU total for the rate control stage.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   frame_start_i      pulse: clear all counters, enter COUNT (highest priority)
//   frame_end_i        pulse: leave COUNT after any same-cycle LCU latch
//   bits_val_i         bits_num_i valid this cycle
//   bits_num_i         bits emitted this cycle
//   ctu_end_i          pulse: last cycle of the current LCU
//   lcu_bitnum_o       saturated bit count of the last completed LCU
//   lcu_bitnum_vld_o   1-cycle pulse when lcu_bitnum_o is updated
//   lcu_sat_o          last latched LCU count saturated
//   frame_bitnum_o     saturated running frame total
//   ctu_cnt_o          LCUs latched since frame start (wraps)
//   busy_o             high while counting a frame
module rc_lcu_bitcnt #(
    parameter int BIT_IN_W = 5,
    parameter int LCU_W    = 16,
    parameter int FRAME_W  = 32,
    parameter int CTU_W    = 13
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                frame_start_i,
    input  logic                frame_end_i,
    input  logic                bits_val_i,
    input  logic [BIT_IN_W-1:0] bits_num_i,
    input  logic                ctu_end_i,
    output logic [LCU_W-1:0]    lcu_bitnum_o,
    output logic                lcu_bitnum_vld_o,
    output logic                lcu_sat_o,
    output logic [FRAME_W-1:0]  frame_bitnum_o,
    output logic [CTU_W-1:0]    ctu_cnt_o,
    output logic                busy_o
);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    state_t               r_state;
    logic [LCU_W-1:0]     r_lcu_acc;
    // Sticky: the true LCU sum has exceeded the accumulator range at some point,
    // so an exact all-ones total is distinguishable from a clipped one.
    logic                 r_lcu_ovf;
    logic [LCU_W-1:0]     r_lcu_bitnum;
    logic                 r_lcu_vld;
    logic                 r_lcu_sat;
    logic [FRAME_W-1:0]   r_frame_bitnum;
    logic [CTU_W-1:0]     r_ctu_cnt;

    logic [BIT_IN_W-1:0]  w_bits;
    logic [LCU_W:0]       w_lcu_sum;
    logic [FRAME_W:0]     w_frame_sum;
    logic [LCU_W-1:0]     w_lcu_sat_val;
    logic [FRAME_W-1:0]   w_frame_sat_val;
    logic                 w_lcu_ovf_tot;

    assign w_bits          = bits_val_i ? bits_num_i : '0;
    // One extra bit of headroom: the carry out is the saturation indicator.
    assign w_lcu_sum       = {1'b0, r_lcu_acc} + {{(LCU_W + 1 - BIT_IN_W){1'b0}}, w_bits};
    assign w_frame_sum     = {1'b0, r_frame_bitnum} + {{(FRAME_W + 1 - BIT_IN_W){1'b0}}, w_bits};
    assign w_lcu_sat_val   = w_lcu_sum[LCU_W] ? '1 : w_lcu_sum[LCU_W-1:0];
    assign w_frame_sat_val = w_frame_sum[FRAME_W] ? '1 : w_frame_sum[FRAME_W-1:0];
    assign w_lcu_ovf_tot   = r_lcu_ovf | w_lcu_sum[LCU_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_lcu_acc      <= '0;
            r_lcu_ovf      <= 1'b0;
            r_lcu_bitnum   <= '0;
            r_lcu_vld      <= 1'b0;
            r_lcu_sat      <= 1'b0;
            r_frame_bitnum <= '0;
            r_ctu_cnt      <= '0;
        end else begin
            r_lcu_vld <= 1'b0;
            if (frame_start_i) begin
                // Restart from either state; same-cycle bits and LCU end are dropped.
                r_state        <= S_COUNT;
                r_lcu_acc      <= '0;
                r_lcu_ovf      <= 1'b0;
                r_lcu_bitnum   <= '0;
                r_lcu_sat      <= 1'b0;
                r_frame_bitnum <= '0;
                r_ctu_cnt      <= '0;
            end else if (r_state == S_COUNT) begin
                r_frame_bitnum <= w_frame_sat_val;
                if (ctu_end_i) begin
                    // Bits of the ending cycle belong to the ending LCU.
                    r_lcu_bitnum <= w_lcu_sat_val;
                    r_lcu_sat    <= w_lcu_ovf_tot;
                    r_lcu_vld    <= 1'b1;
                    r_ctu_cnt    <= r_ctu_cnt + CTU_W'(1);
                    r_lcu_acc    <= '0;
                    r_lcu_ovf    <= 1'b0;
                end else if (frame_end_i) begin
                    // Partial LCU at frame end is discarded.
                    r_lcu_acc    <= '0;
                    r_lcu_ovf    <= 1'b0;
                end else begin
                    r_lcu_acc    <= w_lcu_sat_val;
                    r_lcu_ovf    <= w_lcu_ovf_tot;
                end
                if (frame_end_i) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign lcu_bitnum_o     = r_lcu_bitnum;
    assign lcu_bitnum_vld_o = r_lcu_vld;
    assign lcu_sat_o        = r_lcu_sat;
    assign frame_bitnum_o   = r_frame_bitnum;
    assign ctu_cnt_o        = r_ctu_cnt;
    assign busy_o           = (r_state == S_COUNT);

endmodule

// File: tb/tb_rc_lcu_bitcnt.sv
// tb/tb_rc_lcu_bitcnt.sv - self-checking bench for rc_lcu_bitcnt
module tb_rc_lcu_bitcnt;

    logic        clk;
    logic        rstn;
    logic        frame_start_i;
    logic        frame_end_i;
    logic        bits_val_i;
    logic [4:0]  bits_num_i;
    logic        ctu_end_i;
    logic [15:0] lcu_bitnum_o;
    logic        lcu_bitnum_vld_o;
    logic        lcu_sat_o;
    logic [31:0] frame_bitnum_o;
    logic [12:0] ctu_cnt_o;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: true (unbounded) sums, clipped only when compared.
    bit     m_busy;
    longint m_lcu_true;
    longint m_frame_true;
    longint m_cnt;
    longint m_lcu_out;
    longint m_sat_out;
    longint m_vld;

    rc_lcu_bitcnt dut (
        .clk              (clk),
        .rstn             (rstn),
        .frame_start_i    (frame_start_i),
        .frame_end_i      (frame_end_i),
        .bits_val_i       (bits_val_i),
        .bits_num_i       (bits_num_i),
        .ctu_end_i        (ctu_end_i),
        .lcu_bitnum_o     (lcu_bitnum_o),
        .lcu_bitnum_vld_o (lcu_bitnum_vld_o),
        .lcu_sat_o        (lcu_sat_o),
        .frame_bitnum_o   (frame_bitnum_o),
        .ctu_cnt_o        (ctu_cnt_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint clip(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":lcu"},   longint'(lcu_bitnum_o),     clip(m_lcu_out, 65535));
        chk({tag, ":vld"},   longint'(lcu_bitnum_vld_o), m_vld);
        chk({tag, ":sat"},   longint'(lcu_sat_o),        m_sat_out);
        chk({tag, ":frame"}, longint'(frame_bitnum_o),   clip(m_frame_true, 64'hFFFF_FFFF));
        chk({tag, ":cnt"},   longint'(ctu_cnt_o),        m_cnt);
        chk({tag, ":busy"},  longint'(busy_o),           longint'(m_busy));
    endtask

    task automatic model_reset();
        m_busy = 0; m_lcu_true = 0; m_frame_true = 0; m_cnt = 0;
        m_lcu_out = 0; m_sat_out = 0; m_vld = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit fs, input bit fe, input bit bv, input int bn, input bit ce,
                        input string tag);
        longint b;
        frame_start_i = fs; frame_end_i = fe; bits_val_i = bv;
        bits_num_i = 5'(bn); ctu_end_i = ce;
        m_vld = 0;
        if (fs) begin
            m_busy = 1; m_lcu_true = 0; m_frame_true = 0; m_cnt = 0;
            m_lcu_out = 0; m_sat_out = 0;
        end else if (m_busy) begin
            b = bv ? longint'(bn) : 0;
            m_lcu_true   += b;
            m_frame_true += b;
            if (ce) begin
                m_lcu_out  = clip(m_lcu_true, 65535);
                m_sat_out  = (m_lcu_true > 65535) ? 1 : 0;
                m_cnt      = (m_cnt + 1) % 8192;
                m_vld      = 1;
                m_lcu_true = 0;
            end
            if (fe) begin
                m_busy = 0;
                m_lcu_true = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
        frame_start_i = 0; frame_end_i = 0; bits_val_i = 0; bits_num_i = 0; ctu_end_i = 0;
    endtask

    initial begin
        int nb;
        bit ce;
        bit fe;
        rstn = 1'b0;
        frame_start_i = 0; frame_end_i = 0; bits_val_i = 0; bits_num_i = 0; ctu_end_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rstn = 1'b1;

        // Idle: bits and LCU end ignored.
        step(0, 0, 1, 9, 1, "idle_ignore");

        // 10 cycles x 3 bits, LCU end on the 10th.
        step(1, 0, 0, 0, 0, "fs1");
        for (int i = 0; i < 9; i++) step(0, 0, 1, 3, 0, "lcu30_acc");
        step(0, 0, 1, 3, 1, "lcu30_end");
        chk("lcu30_value", longint'(lcu_bitnum_o), 30);
        step(0, 0, 0, 0, 0, "lcu30_vld_drop");

        // Three LCUs 100 / 0 / 250 with back-to-back ends for the empty one.
        step(1, 0, 0, 0, 0, "fs2");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 25, 0, "lcu100_acc");
        step(0, 0, 0, 0, 1, "lcu100_end");
        step(0, 0, 0, 0, 1, "lcu0_end");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 25, (i == 9), "lcu250");
        chk("three_frame", longint'(frame_bitnum_o), 350);
        chk("three_cnt", longint'(ctu_cnt_o), 3);

        // Saturating LCU: 2200 x 31 = 68200, then a 5-bit LCU.
        step(1, 0, 0, 0, 0, "fs3");
        for (int i = 0; i < 2200; i++) step(0, 0, 1, 31, (i == 2199), "lcu_sat");
        chk("sat_value", longint'(lcu_bitnum_o), 65535);
        chk("sat_flag", longint'(lcu_sat_o), 1);
        step(0, 0, 1, 5, 1, "lcu5");
        chk("after_sat_frame", longint'(frame_bitnum_o), 68205);
        chk("after_sat_flag", longint'(lcu_sat_o), 0);

        // Restart mid-frame with bits and LCU end in the same cycle.
        step(0, 0, 1, 17, 0, "pre_restart");
        step(1, 0, 1, 20, 1, "restart");

        // Frame end together with LCU end and 7 bits.
        step(0, 0, 1, 10, 0, "fe_acc");
        step(0, 1, 1, 7, 1, "fe_latch");
        chk("fe_lcu17", longint'(lcu_bitnum_o), 17);
        step(0, 0, 1, 9, 0, "after_fe_ignored");
        step(0, 0, 1, 9, 1, "after_fe_ignored2");

        // Asynchronous reset mid-LCU.
        step(1, 0, 0, 0, 0, "fs_rst");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 11, (i == 2), "pre_rst");
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(0, 0, 1, 13, 1, "post_rst_ignored");

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            step(1, 0, 0, 0, 0, "rnd_fs");
            for (int c = 0; c < 300; c++) begin
                nb = int'($urandom_range(0, 31));
                ce = ($urandom_range(0, 9) == 0);
                fe = (c == 299) || ($urandom_range(0, 199) == 0);
                if (fe && !ce) step(0, 1, 0, 0, 0, "rnd_fe");
                else           step(($urandom_range(0, 149) == 0), fe,
                                    ($urandom_range(0, 3) != 0), nb, ce, "rnd");
                if (!m_busy) break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
